// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Purpose
//   Program-counter sequencer for a small in-order core. Decoded instruction
//   classes become PC redirect controls: relative branches, absolute jumps, and
//   call/return through a small return-address stack (RAS). A sticky error flag
//   and a saturating retired-instruction counter are also kept here.
//
//   The redirect outputs are Mealy outputs, combinational from the state and
//   the current inputs. The external PC register consumes them on the same
//   rising edge.
//
// Build option
//   PC_SEQ_RAS_EN  When defined, the return-address stack is built.
//                  When undefined, there is no RAS storage. CALL is then a
//                  plain absolute jump, and RET flags err and acts as a NOP.
//
// Parameters
//   D          program counter width
//   RAS_DEPTH  return-address stack entries (power of 2, 2..16)
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   start        leave IDLE (ignored in any other state)
//   stall        freeze sequencing this cycle
//   op[2:0]      0 NOP, 1 BRZ_REL, 2 JMP_ABS, 3 CALL, 4 RET, 5 HALT, 6-7 illegal
//   zero_flag    ALU zero condition for BRZ_REL
//   imm[D-1:0]   relative offset (BRZ_REL) or absolute target (JMP_ABS, CALL)
//   prog_ctr     current PC value
//   branch_en    any redirect this cycle
//   reljump_en   PC <= PC + target
//   absjump_en   PC <= target
//   target       redirect value
//   pc_hold      PC keeps its value at the next edge
//   done         high while HALTED
//   err          sticky error flag
//   instr_count  retired-instruction counter, saturating
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int D         = 12,
  parameter int RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stall,
  input  logic [2:0]    op,
  input  logic          zero_flag,
  input  logic [D-1:0]  imm,
  input  logic [D-1:0]  prog_ctr,
  output logic          branch_en,
  output logic          reljump_en,
  output logic          absjump_en,
  output logic [D-1:0]  target,
  output logic          pc_hold,
  output logic          done,
  output logic          err,
  output logic [15:0]   instr_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_BRZ  = 3'd1;
  localparam logic [2:0] OP_JMP  = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_HALT = 3'd5;

  state_t      state_q, state_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;

`ifdef PC_SEQ_RAS_EN
  localparam int AW = $clog2(RAS_DEPTH);
  // The pointer is one bit wider than the index so it can express "full".
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] RAS_FULL = PW'(RAS_DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [D-1:0]  PC_ONE   = D'(1);

  logic [D-1:0]  ras_q [RAS_DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] top_idx;
  logic          ras_empty, ras_full;
  logic          push, pop;

  assign ras_empty = (ptr_q == '0);
  assign ras_full  = (ptr_q == RAS_FULL);
  assign top_idx   = AW'(ptr_q - PTR_ONE);
`else
  // Without the RAS, prog_ctr has no consumer.
  logic unused_prog_ctr;
  assign unused_prog_ctr = ^prog_ctr;
`endif

  // Next state, redirect outputs and bookkeeping.
  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    branch_en  = 1'b0;
    reljump_en = 1'b0;
    absjump_en = 1'b0;
    target     = '0;
    pc_hold    = 1'b1;
`ifdef PC_SEQ_RAS_EN
    push       = 1'b0;
    pop        = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end

      S_RUN: begin
        if (!stall) begin
          pc_hold = 1'b0;
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          case (op)
            OP_NOP: ;
            OP_BRZ: begin
              if (zero_flag) begin
                reljump_en = 1'b1;
                target     = imm;
              end
            end
            OP_JMP: begin
              absjump_en = 1'b1;
              target     = imm;
            end
            OP_CALL: begin
              // The jump is taken even when the push must be dropped.
              absjump_en = 1'b1;
              target     = imm;
`ifdef PC_SEQ_RAS_EN
              if (ras_full) err_d = 1'b1;
              else          push  = 1'b1;
`endif
            end
            OP_RET: begin
`ifdef PC_SEQ_RAS_EN
              if (ras_empty) begin
                err_d = 1'b1;
              end else begin
                absjump_en = 1'b1;
                target     = ras_q[top_idx];
                pop        = 1'b1;
              end
`else
              err_d = 1'b1;
`endif
            end
            OP_HALT: begin
              pc_hold = 1'b1;
              state_d = S_HALTED;
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      default: ;  // HALTED: leaves only through reset
    endcase

    branch_en = reljump_en | absjump_en;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PC_SEQ_RAS_EN
  always_comb begin
    ptr_d = ptr_q;
    if (push)     ptr_d = ptr_q + PTR_ONE;
    else if (pop) ptr_d = ptr_q - PTR_ONE;
  end

  // Clearing the pointer is enough to discard the stack on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  // Stack storage has no reset. push is only possible while ptr_q < RAS_DEPTH,
  // so the low pointer bits index the free slot.
  always_ff @(posedge clk) begin
    if (push) ras_q[ptr_q[AW-1:0]] <= prog_ctr + PC_ONE;
  end
`endif

  assign done        = (state_q == S_HALTED);
  assign err         = err_q;
  assign instr_count = cnt_q;

endmodule
